// File: rtl/uart_cmd_assembler.sv
// UART command assembler: frames header + CMD_BYTES payload + checksum bytes
// from the receiver into command words for the dispatcher, with checksum,
// inter-byte timeout and overrun reporting.
module uart_cmd_assembler #(
  parameter int          CMD_BYTES    = 3,
  parameter logic [7:0]  HDR          = 8'hA5,
  parameter int          TIMEOUT_CLKS = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_rdy,
  input  logic [7:0]             rx_data,
  output logic                   clr_rx_rdy,
  output logic [8*CMD_BYTES-1:0] cmd,
  output logic                   cmd_rdy,
  input  logic                   clr_cmd_rdy,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic                   overrun
);

  localparam int          W      = 8*CMD_BYTES;
  localparam logic [15:0] TO_MAX = 16'(TIMEOUT_CLKS-1);
  localparam logic [3:0]  LAST   = 4'(CMD_BYTES-1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;

  state_t         state, state_nx;
  logic [15:0]    to_cnt;
  logic [3:0]     idx;
  logic [7:0]     sum;
  logic [W-1:0]   shadow;
  logic           accept, expire, pkt_ok, pkt_bad;

  // A byte still flagged while we acknowledge it must not be taken twice.
  assign accept = rx_rdy & ~clr_rx_rdy;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and packet verdict; an accept in the expiry cycle beats the timeout.
  always_comb begin
    state_nx = state;
    expire   = 1'b0;
    pkt_ok   = 1'b0;
    pkt_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && rx_data == HDR) state_nx = PAYLOAD;
      end
      PAYLOAD: begin
        if (accept) begin
          if (idx == LAST) state_nx = CHECK;
        end else if (to_cnt == TO_MAX) begin
          expire   = 1'b1;
          state_nx = IDLE;
        end
      end
      CHECK: begin
        if (accept) begin
          state_nx = IDLE;
          if (rx_data == sum) pkt_ok  = 1'b1;
          else                pkt_bad = 1'b1;
        end else if (to_cnt == TO_MAX) begin
          expire   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Byte acknowledge pulse, one cycle after each accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clr_rx_rdy <= 1'b0;
    else        clr_rx_rdy <= accept;
  end

  // Inter-byte timer: held at zero in IDLE, restarted by every accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      to_cnt <= '0;
    else if (state == IDLE || accept) to_cnt <= '0;
    else                             to_cnt <= to_cnt + 16'd1;
  end

  // Payload shadow (first byte ends up in the MSBs), running sum and byte index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      sum    <= '0;
      shadow <= '0;
    end else if (state == IDLE && accept && rx_data == HDR) begin
      idx <= '0;
      sum <= '0;
    end else if (state == PAYLOAD && accept) begin
      shadow <= W'({shadow, rx_data});
      sum    <= sum + rx_data;
      idx    <= idx + 4'd1;
    end
  end

  // Error pulse and sticky last error code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      err_code <= 2'b00;
    end else begin
      err <= pkt_bad | expire;
      if (pkt_bad)     err_code <= 2'b01;
      else if (expire) err_code <= 2'b10;
    end
  end

  // Command handoff; a completion beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd     <= '0;
      cmd_rdy <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (pkt_ok) cmd <= shadow;
      if (pkt_ok)           cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy) cmd_rdy <= 1'b0;
      if (pkt_ok && cmd_rdy && !clr_cmd_rdy) overrun <= 1'b1;
      else if (clr_cmd_rdy && !pkt_ok)       overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Bench for uart_cmd_assembler: directed test-plan steps followed by random
// packets, junk and gaps, checked against a byte-level packet model.
module tb_uart_cmd_assembler;
  localparam int         N  = 3;
  localparam logic [7:0] H  = 8'hA5;
  localparam int         TO = 100;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          rx_rdy = 1'b0, clr_cmd_rdy = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          clr_rx_rdy, cmd_rdy, err, overrun;
  logic [8*N-1:0] cmd;
  logic [1:0]    err_code;

  uart_cmd_assembler #(.CMD_BYTES(N), .HDR(H), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .err(err), .err_code(err_code), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, fails = 0;

  // Reference model state: bytes seen since a header, expected outputs.
  bit          in_frame = 0;
  logic [7:0]  frame[$];
  logic [23:0] e_cmd = '0;
  bit          e_rdy = 0, e_ovr = 0;
  logic [1:0]  e_code = 2'b00;
  int unsigned last_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One quiet cycle: a frame whose last accept lies TO cycles back times out now.
  task automatic tick();
    bit e_err;
    @(negedge clk);
    e_err = 0;
    if (in_frame && (cyc - last_acc) == TO) begin
      e_err = 1; in_frame = 0; e_code = 2'b10;
    end
    chk("err_quiet", {31'b0, err}, {31'b0, e_err});
    if (e_err) chk("code_timeout", {30'b0, err_code}, {30'b0, e_code});
  endtask

  task automatic idle(input int g);
    repeat (g) tick();
  endtask

  // Offer one byte like a UART receiver would, optionally with a dispatcher clear.
  task automatic send(input logic [7:0] b, input bit clr);
    bit hold, e_err, set;
    logic [7:0] s;
    logic [23:0] nc;
    tick();
    rx_rdy = 1; rx_data = b; clr_cmd_rdy = clr;
    hold = 1'($urandom_range(0, 1));
    last_acc = cyc + 1;
    e_err = 0; set = 0; nc = '0;
    if (!in_frame) begin
      if (b == H) begin in_frame = 1; frame.delete(); end
    end else if (frame.size() < N) begin
      frame.push_back(b);
    end else begin
      s = 8'h00;
      foreach (frame[i]) s = s + frame[i];
      if (s == b) begin
        set = 1;
        foreach (frame[i]) nc = {nc[15:0], frame[i]};
      end else begin
        e_err = 1; e_code = 2'b01;
      end
      in_frame = 0;
    end
    if (set) begin
      if (e_rdy && !clr) e_ovr = 1;
      e_rdy = 1; e_cmd = nc;
    end else if (clr) begin
      e_rdy = 0; e_ovr = 0;
    end
    @(negedge clk);
    clr_cmd_rdy = 0;
    chk("clr_rx_rdy_hi", {31'b0, clr_rx_rdy}, 32'd1);
    chk("err", {31'b0, err}, {31'b0, e_err});
    chk("err_code", {30'b0, err_code}, {30'b0, e_code});
    chk("cmd_rdy", {31'b0, cmd_rdy}, {31'b0, e_rdy});
    chk("cmd", {8'b0, cmd}, {8'b0, e_cmd});
    chk("overrun", {31'b0, overrun}, {31'b0, e_ovr});
    if (!hold) rx_rdy = 0;
    @(negedge clk);
    rx_rdy = 0;
    chk("clr_rx_rdy_lo", {31'b0, clr_rx_rdy}, 32'd0);
    chk("err_lo", {31'b0, err}, 32'd0);
  endtask

  task automatic pkt(input logic [23:0] pl, input bit bad, input bit clr_last, input int gmax);
    logic [7:0] s;
    s = pl[23:16] + pl[15:8] + pl[7:0];
    idle($urandom_range(0, gmax)); send(H, 0);
    for (int i = 0; i < N; i++) begin
      idle($urandom_range(0, gmax)); send(pl[23-8*i -: 8], 0);
    end
    idle($urandom_range(0, gmax)); send(bad ? (s ^ 8'h01) : s, clr_last);
  endtask

  task automatic clear();
    tick();
    clr_cmd_rdy = 1; e_rdy = 0; e_ovr = 0;
    tick();
    clr_cmd_rdy = 0;
    chk("clear_rdy", {31'b0, cmd_rdy}, 32'd0);
    chk("clear_ovr", {31'b0, overrun}, 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_clr_rx"}, {31'b0, clr_rx_rdy}, 32'd0);
    chk({tag, "_cmd"}, {8'b0, cmd}, 32'd0);
    chk({tag, "_cmd_rdy"}, {31'b0, cmd_rdy}, 32'd0);
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
    chk({tag, "_err_code"}, {30'b0, err_code}, 32'd0);
    chk({tag, "_overrun"}, {31'b0, overrun}, 32'd0);
  endtask

  task automatic do_reset();
    tick();
    rx_rdy = 0; rst_n = 0;
    #1 check_zero("rst_mid");
    in_frame = 0; e_cmd = '0; e_rdy = 0; e_ovr = 0; e_code = 2'b00;
    @(negedge clk); rst_n = 1;
  endtask

  initial begin
    int kind;
    logic [7:0] jb;
    #1 check_zero("rst");
    @(negedge clk); rst_n = 1;

    // Basic packet.
    pkt(24'h123456, 0, 0, 0);
    chk("basic_cmd", {8'b0, cmd}, 32'h123456);
    clear();
    // Leading junk is discarded silently.
    send(8'h00, 0); send(8'hFF, 0);
    pkt(24'h010203, 0, 0, 0);
    chk("junk_cmd", {8'b0, cmd}, 32'h010203);
    clear();
    // Checksum failure, then recovery.
    pkt(24'h123456, 1, 0, 0);
    chk("bad_rdy", {31'b0, cmd_rdy}, 32'd0);
    pkt(24'h010101, 0, 0, 0);
    chk("recover_cmd", {8'b0, cmd}, 32'h010101);
    clear();
    // Timeout after a partial packet, then a normal packet.
    send(H, 0); send(8'h12, 0);
    idle(TO + 20);
    chk("to_code", {30'b0, err_code}, 32'd2);
    pkt(24'h0A0B0C, 0, 0, 0);
    clear();
    // Gap ending exactly in the expiry cycle: the byte wins.
    send(H, 0); send(8'h12, 0);
    idle(TO - 3);
    send(8'h34, 0); send(8'h56, 0); send(8'h9C, 0);
    chk("edge_cmd", {8'b0, cmd}, 32'h123456);
    clear();
    // Overrun, clear, then clear coincident with completion.
    pkt(24'h111111, 0, 0, 0);
    pkt(24'h222222, 0, 0, 0);
    chk("ovr_set", {31'b0, overrun}, 32'd1);
    clear();
    pkt(24'h333333, 0, 0, 0);
    pkt(24'h444444, 0, 1, 0);
    chk("coinc_rdy", {31'b0, cmd_rdy}, 32'd1);
    chk("coinc_ovr", {31'b0, overrun}, 32'd0);
    clear();
    // Reset mid-packet.
    send(H, 0); send(8'h12, 0);
    do_reset();
    pkt(24'hAABBCC, 0, 0, 0);
    chk("post_rst_cmd", {8'b0, cmd}, 32'hAABBCC);

    // Random traffic.
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1: begin
          jb = 8'($urandom);
          if (jb == H) jb = 8'h00;
          send(jb, 1'($urandom_range(0, 1)));
        end
        2:       pkt(24'($urandom), 1, 1'($urandom_range(0, 1)), 4);
        3:       clear();
        4:       idle($urandom_range(0, 6));
        default: pkt(24'($urandom), 0, 1'($urandom_range(0, 1)), 4);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
